// File: rtl/seven_segment_scanner.sv
// Four-digit multiplexed 7-segment driver with shadow/pending content registers.
// All outputs are registered and show the scan position held by the state registers one cycle earlier.

module seven_segment_digit_decoder (
    input  logic [4:0] code,
    output logic [6:0] seg
);

    // Active-low {a..g} pattern; bit 4 of the code forces the digit dark.
    always_comb begin
        seg = 7'b1111111;
        case (code)
            5'h00:   seg = 7'b0000001;
            5'h01:   seg = 7'b1001111;
            5'h02:   seg = 7'b0010010;
            5'h03:   seg = 7'b0000110;
            5'h04:   seg = 7'b1001100;
            5'h05:   seg = 7'b0100100;
            5'h06:   seg = 7'b0100000;
            5'h07:   seg = 7'b0001111;
            5'h08:   seg = 7'b0000000;
            5'h09:   seg = 7'b0000100;
            5'h0A:   seg = 7'b0001000;
            5'h0B:   seg = 7'b1100000;
            5'h0C:   seg = 7'b0110001;
            5'h0D:   seg = 7'b1000010;
            5'h0E:   seg = 7'b0110000;
            5'h0F:   seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

module seven_segment_scanner #(
    parameter int DIGIT_CYCLES = 50000,
    parameter int GAP_CYCLES   = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  blank,
    input  logic [3:0]  dp,
    input  logic        load,
    input  logic        enable,
    output logic        load_ack,
    output logic [3:0]  anode,
    output logic [6:0]  segment,
    output logic        dp_n
);

    localparam int CNT_MAX = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
    localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : {CW{1'b0}};

    typedef enum logic [0:0] {SHOW = 1'b0, GAP = 1'b1} state_t;

    state_t        state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic [1:0]    idx_r, idx_nxt_s;
    logic          frame_end_s;

    logic [15:0]   value_r, pend_value_r;
    logic [3:0]    blank_r, pend_blank_r;
    logic [3:0]    dp_r, pend_dp_r;
    logic          pend_r;
    logic          commit_r;

    logic [3:0]    nibble_s;
    logic [6:0]    seg_s;

    // Scan sequencing; frame_end_s flags the last cycle before index-0 SHOW starts.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        idx_nxt_s   = idx_r;
        frame_end_s = 1'b0;
        case (state_r)
            SHOW: begin
                if (cnt_r == DIGIT_LAST) begin
                    cnt_nxt_s = {CW{1'b0}};
                    idx_nxt_s = idx_r + 2'd1;
                    if (GAP_CYCLES == 0) begin
                        state_nxt_s = SHOW;
                        frame_end_s = (idx_r == 2'd3);
                    end else begin
                        state_nxt_s = GAP;
                        frame_end_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = SHOW;
                end
            end
            GAP: begin
                // The index already advanced on entry, so digit 3's gap carries index 0.
                if (cnt_r == GAP_LAST) begin
                    cnt_nxt_s   = {CW{1'b0}};
                    state_nxt_s = SHOW;
                    frame_end_s = (idx_r == 2'd0);
                end else begin
                    state_nxt_s = GAP;
                end
            end
            default: begin
                state_nxt_s = SHOW;
                cnt_nxt_s   = {CW{1'b0}};
                idx_nxt_s   = 2'd0;
            end
        endcase
    end

    // State, counter and digit index registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= SHOW;
            cnt_r   <= {CW{1'b0}};
            idx_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Pending/shadow content; shadow only moves at a frame boundary, a coincident load wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_r      <= 16'h0000;
            blank_r      <= 4'b1111;
            dp_r         <= 4'b0000;
            pend_value_r <= 16'h0000;
            pend_blank_r <= 4'b1111;
            pend_dp_r    <= 4'b0000;
            pend_r       <= 1'b0;
            commit_r     <= 1'b0;
        end else if (frame_end_s) begin
            commit_r <= load | pend_r;
            pend_r   <= 1'b0;
            if (load) begin
                value_r <= value;
                blank_r <= blank;
                dp_r    <= dp;
            end else if (pend_r) begin
                value_r <= pend_value_r;
                blank_r <= pend_blank_r;
                dp_r    <= pend_dp_r;
            end
        end else begin
            commit_r <= 1'b0;
            if (load) begin
                pend_value_r <= value;
                pend_blank_r <= blank;
                pend_dp_r    <= dp;
                pend_r       <= 1'b1;
            end
        end
    end

    // Select the current digit's nibble from the shadow value.
    always_comb begin
        nibble_s = 4'h0;
        case (idx_r)
            2'd0:    nibble_s = value_r[3:0];
            2'd1:    nibble_s = value_r[7:4];
            2'd2:    nibble_s = value_r[11:8];
            2'd3:    nibble_s = value_r[15:12];
            default: nibble_s = 4'h0;
        endcase
    end

    seven_segment_digit_decoder u_decoder (
        .code (({blank_r[idx_r], nibble_s})),
        .seg  (seg_s)
    );

    // Output registers; commit_r is high in the first index-0 cycle, so the ack lines up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            anode    <= 4'b1111;
            segment  <= 7'b1111111;
            dp_n     <= 1'b1;
            load_ack <= 1'b0;
        end else begin
            load_ack <= commit_r;
            if (state_r == SHOW) begin
                anode   <= enable ? ~(4'b0001 << idx_r) : 4'b1111;
                segment <= seg_s;
                dp_n    <= ~dp_r[idx_r];
            end else begin
                anode   <= 4'b1111;
                segment <= 7'b1111111;
                dp_n    <= 1'b1;
            end
        end
    end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Time-multiplexes the four-digit common-anode 7-segment display of the starter kit, which has one shared active-low segment bus and four active-low anodes.
- Holds a 16-bit hex value plus per-digit blank and decimal-point flags in shadow registers.
- Scans digits 0..3 continuously, with a programmable dead-time gap between digits to suppress ghosting.
- New content is accepted via a load strobe and applied only at a frame boundary, so the display never tears.

Parameters:
- DIGIT_CYCLES, 50000, clock cycles each digit is driven (1 kHz per digit at 50 MHz); must be >= 1
- GAP_CYCLES, 500, clock cycles with all anodes off after each digit; 0 means no gap state

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active low
- value  input  16  hex digits; digit i = value[4i+3:4i], digit 0 is rightmost
- blank  input  4  per-digit blank request; 1 = digit dark
- dp  input  4  per-digit decimal point; 1 = lit
- load  input  1  one-cycle strobe capturing value/blank/dp
- enable  input  1  0 forces all anodes off; scanning continues
- load_ack  output  1  one-cycle pulse when captured data becomes visible
- anode  output  4  active-low digit enables
- segment  output  7  active-low segments, order {a,b,c,d,e,f,g}, MSB = a
- dp_n  output  1  active-low decimal point

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. This is fixed.
- All outputs are registers. There is no combinational path from any input to any output.
- Reset (rst_n=0 at a clk edge):
  - anode=4'b1111, segment=7'b1111111, dp_n=1, load_ack=0
  - state=SHOW, digit index=0, cycle counter=0
  - shadow: value=16'h0000, blank=4'b1111, dp=4'b0000; pending flag=0
  - The display is dark until the first load.
- FSM states: SHOW and GAP.
  - SHOW lasts DIGIT_CYCLES cycles. anode has the single bit for the current index low (index 0 gives 4'b1110). segment carries the decoded shadow nibble. dp_n = ~dp[index].
  - GAP lasts GAP_CYCLES cycles: anode=4'b1111, segment=7'b1111111, dp_n=1. The index increments mod 4 on the SHOW->GAP transition.
  - If GAP_CYCLES=0, SHOW->SHOW with the index increment; no GAP cycle is produced.
  - Counter runs 0..N-1 per state and resets on every state change.
  - Frame period = 4*(DIGIT_CYCLES+GAP_CYCLES) cycles.
- Decoding:
  - Uses the codebase's standard 5-bit-code digit decoder, instantiated once and shared.
  - Code = {blank[index], nibble}. Any code >= 16 yields 7'b1111111.
  - Hex encoding (active low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000.
  - A blanked digit still has its anode driven. dp_n follows dp[index] regardless of blank.
- enable=0: anode forced 4'b1111 on the next edge. Segment/dp_n, FSM, counter, index and load logic are unaffected.
- Frame boundary: the cycle in which SHOW for index 0 begins, i.e. the transition from the last cycle of digit 3 (or of its GAP).
- Load handshake:
  - load=1 copies value/blank/dp into pending registers and sets the pending flag.
  - A load while pending is already set overwrites pending (latest wins).
  - At a frame boundary with pending set: pending is copied to shadow, pending is cleared, and load_ack=1 for exactly that cycle. Outputs of that first index-0 cycle already show the new data.
  - Load coinciding with a boundary: the new inputs go directly to shadow, pending is cleared, and load_ack pulses. Any older pending data is discarded.
  - Worst-case latency from load to visible is one frame period plus 1 cycle.
- Shadow registers never change except at a frame boundary or on reset.
- Reset mid-frame or with load pending: pending is discarded, no load_ack, and the next cycle restarts at index 0 SHOW with dark shadow.
- Counter width: clog2(max(DIGIT_CYCLES,GAP_CYCLES)+1) bits, with no overflow at the limits.

Test Plan:
- Use DIGIT_CYCLES=4 and GAP_CYCLES=1 unless stated otherwise.
- Reset then idle 20 cycles: anode cycles 1110 x4, 1111 x1, 1101 x4, 1111, 1011 ..., with segment=7'b1111111 throughout and load_ack never high.
- load with value=16'h12AF, blank=0, dp=4'b0100 mid-frame: load_ack pulses at the next index-0 start.
  - Digits 0..3 then show 0111000, 0001000, 0010010, 1001111.
  - dp_n=0 only while anode=1011.
- Two loads in one frame (16'h1111, then 16'h2222) followed by load exactly on a frame boundary (16'h3333): single ack per boundary; displays 2222, then 3333 from that same boundary cycle.
- blank=4'b1010 with value=16'h8888: anodes 1101 and 0111 are driven with segment=1111111, while the other digits show 0000000.
- enable=0 for one full frame: anode stuck at 1111, index sequence and ack timing unchanged. Re-enable resumes at the correct index.
- GAP_CYCLES=0: no 1111 anode cycles, frame=16 cycles. Reset asserted with load pending: no load_ack; after release the display is dark at index 0.
